// File: rtl/noc_local_inject_arbiter_pkg.sv
// Shared types and helpers for tile-level round-robin arbiters.
package tile_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Index width for an N-entry requester set; never narrower than one bit.
    function automatic int req_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_priority_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic             found
);

    always_comb begin
        int               s;
        logic [IDX_W-1:0] idx;
        winner = '0;
        found  = 1'b0;
        s      = 0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            s = int'(ptr) + k;
            if (s >= N_REQ) s = s - N_REQ;
            idx = IDX_W'(s);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_local_inject_arbiter.sv
// Packet-level round-robin arbiter sharing the tile's local NoC injection stream.
module noc_local_inject_arbiter
    import tile_arb_pkg::*;
#(
    parameter int BW            = 32,
    parameter int BWB           = BW / 8,
    parameter int N_REQ         = 2,
    parameter int MAX_PKT_BEATS = 256,
    parameter int CNT_W         = 16
) (
    input  logic                   clk_line,
    input  logic                   clk_line_rst_high,
    input  logic                   arb_enable,
    input  logic [N_REQ-1:0]       req_TVALID,
    input  logic [N_REQ*BW-1:0]    req_TDATA,
    input  logic [N_REQ*BWB-1:0]   req_TKEEP,
    input  logic [N_REQ-1:0]       req_TLAST,
    output logic [N_REQ-1:0]       req_TREADY,
    output logic                   out_TVALID,
    output logic [BW-1:0]          out_TDATA,
    output logic [BWB-1:0]         out_TKEEP,
    output logic                   out_TLAST,
    input  logic                   out_TREADY,
    output logic [N_REQ-1:0]       grant_onehot,
    output logic                   busy,
    output logic [N_REQ*CNT_W-1:0] pkt_count,
    output logic                   oversize_err
);

    localparam int REQ_IDX_W = req_idx_w(N_REQ);
    localparam int BCW       = $clog2(MAX_PKT_BEATS + 2);

    arb_state_t                  state, state_nxt;
    logic [REQ_IDX_W-1:0]        rr_ptr, owner;
    logic [N_REQ-1:0]            pick;
    logic                        pick_vld;
    logic [BCW-1:0]              beat_cnt;
    logic [N_REQ-1:0][CNT_W-1:0] cnt;
    logic [N_REQ-1:0][BW-1:0]    data_v;
    logic [N_REQ-1:0][BWB-1:0]   keep_v;
    logic                        xfer;
    logic                        win;

    assign data_v    = req_TDATA;
    assign keep_v    = req_TKEEP;
    assign pkt_count = cnt;
    assign busy      = (state == BUSY);

    rr_priority_picker #(.N_REQ(N_REQ), .IDX_W(REQ_IDX_W)) u_pick (
        .req    (req_TVALID),
        .ptr    (rr_ptr),
        .winner (pick),
        .found  (pick_vld)
    );

    always_comb begin
        owner = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant_onehot[i]) owner = REQ_IDX_W'(i);
    end

    // Data path is a pure mux: the owner's stream appears on the port with no latency.
    always_comb begin
        out_TVALID = busy & req_TVALID[owner];
        out_TDATA  = data_v[owner];
        out_TKEEP  = keep_v[owner];
        out_TLAST  = req_TLAST[owner];
        req_TREADY = busy ? (grant_onehot & {N_REQ{out_TREADY}}) : '0;
    end

    assign xfer = out_TVALID & out_TREADY;
    assign win  = (state == IDLE) & arb_enable & pick_vld;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win) state_nxt = BUSY;
            BUSY:    if (xfer && out_TLAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_onehot <= '0;
            beat_cnt     <= '0;
            cnt          <= '0;
            oversize_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (win) grant_onehot <= pick;
            if (xfer) begin
                if (out_TLAST) begin
                    grant_onehot <= '0;
                    rr_ptr       <= REQ_IDX_W'(rr_next(int'(owner), N_REQ));
                    cnt[owner]   <= cnt[owner] + 1'b1;
                    beat_cnt     <= '0;
                end else begin
                    if (beat_cnt != BCW'(MAX_PKT_BEATS + 1)) beat_cnt <= beat_cnt + 1'b1;
                    // Flag only; the packet is still forwarded in full.
                    if (beat_cnt == BCW'(MAX_PKT_BEATS - 1)) oversize_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Scoreboard bench for noc_local_inject_arbiter (N_REQ=2, MAX_PKT_BEATS=4).
module tb_noc_local_inject_arbiter;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        arb_enable;
    logic [1:0]  req_TVALID, req_TLAST, req_TREADY;
    logic [63:0] req_TDATA;
    logic [7:0]  req_TKEEP;
    logic        out_TVALID, out_TLAST, out_TREADY;
    logic [31:0] out_TDATA;
    logic [3:0]  out_TKEEP;
    logic [1:0]  grant_onehot;
    logic        busy;
    logic [31:0] pkt_count;
    logic        oversize_err;

    beat_t src0[$], src1[$], exp_q[$];
    logic [1:0] hold;
    int n_cmp, n_err;

    logic [1:0] s_grant, s_tready;
    logic       s_busy, s_valid, s_xfer;

    noc_local_inject_arbiter #(
        .BW(32), .BWB(4), .N_REQ(2), .MAX_PKT_BEATS(4), .CNT_W(16)
    ) dut (
        .clk_line          (clk),
        .clk_line_rst_high (rst),
        .arb_enable        (arb_enable),
        .req_TVALID        (req_TVALID),
        .req_TDATA         (req_TDATA),
        .req_TKEEP         (req_TKEEP),
        .req_TLAST         (req_TLAST),
        .req_TREADY        (req_TREADY),
        .out_TVALID        (out_TVALID),
        .out_TDATA         (out_TDATA),
        .out_TKEEP         (out_TKEEP),
        .out_TLAST         (out_TLAST),
        .out_TREADY        (out_TREADY),
        .grant_onehot      (grant_onehot),
        .busy              (busy),
        .pkt_count         (pkt_count),
        .oversize_err      (oversize_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        return b;
    endfunction

    // One clock: drive requesters from their queues, sample at negedge, score, pop.
    task automatic tick();
        beat_t b;
        if (src0.size() > 0) begin
            req_TVALID[0] = !hold[0];
            req_TDATA[31:0] = src0[0].d; req_TKEEP[3:0] = src0[0].k; req_TLAST[0] = src0[0].l;
        end else begin
            req_TVALID[0] = 1'b0; req_TDATA[31:0] = '0; req_TKEEP[3:0] = '0; req_TLAST[0] = 1'b0;
        end
        if (src1.size() > 0) begin
            req_TVALID[1] = !hold[1];
            req_TDATA[63:32] = src1[0].d; req_TKEEP[7:4] = src1[0].k; req_TLAST[1] = src1[0].l;
        end else begin
            req_TVALID[1] = 1'b0; req_TDATA[63:32] = '0; req_TKEEP[7:4] = '0; req_TLAST[1] = 1'b0;
        end
        @(negedge clk);
        s_grant = grant_onehot; s_busy = busy; s_valid = out_TVALID;
        s_tready = req_TREADY; s_xfer = out_TVALID && out_TREADY;
        if (s_xfer) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL beat_unexpected: got data=%h last=%b, required no beat", out_TDATA, out_TLAST);
            end else begin
                b = exp_q.pop_front();
                if ({out_TDATA, out_TKEEP, out_TLAST} !== {b.d, b.k, b.l}) begin
                    n_err++;
                    $display("FAIL beat_data: got %h/%h/%b, required %h/%h/%b",
                             out_TDATA, out_TKEEP, out_TLAST, b.d, b.k, b.l);
                end
            end
        end
        if (req_TVALID[0] && req_TREADY[0]) void'(src0.pop_front());
        if (req_TVALID[1] && req_TREADY[1]) void'(src1.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_empty(input int maxc, output int n);
        n = 0;
        while (exp_q.size() > 0 && n < maxc) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src0.delete(); src1.delete(); exp_q.delete();
        hold = '0; arb_enable = 1'b1; out_TREADY = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; arb_enable = 1'b1; out_TREADY = 1'b1; hold = '0;
        tick(); tick();
        n_cmp++;
        if ({s_valid, s_grant, s_busy, s_tready} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b grant=%b busy=%b tready=%b, required all 0",
                     s_valid, s_grant, s_busy, s_tready);
        end
        n_cmp++;
        if ({pkt_count, oversize_err} !== 33'b0) begin
            n_err++;
            $display("FAIL reset_counters: got cnt=%h err=%b, required 0/0", pkt_count, oversize_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [2:0] want;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            src0.push_back(mk(32'hA0 + i, (i == 2) ? 4'h3 : 4'hF, i == 2));
            exp_q.push_back(mk(32'hA0 + i, (i == 2) ? 4'h3 : 4'hF, i == 2));
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            want = (c >= 1 && c <= 3) ? 3'b011 : 3'b000;
            n_cmp++;
            if ({s_grant, s_xfer} !== want) begin
                n_err++;
                $display("FAIL single_c%0d: got grant=%b xfer=%b, required grant=%b xfer=%b",
                         c, s_grant, s_xfer, want[2:1], want[0]);
            end
        end
        n_cmp++;
        if (pkt_count !== {16'd0, 16'd1} || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL single_count: got cnt=%h left=%0d, required 00000001/0", pkt_count, exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 2; b++) begin
                src0.push_back(mk(32'h100 + 2*p + b, 4'hF, b == 1));
                src1.push_back(mk(32'h200 + 2*p + b, 4'hF, b == 1));
            end
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 2; b++) exp_q.push_back(mk(32'h100 + 2*p + b, 4'hF, b == 1));
            for (int b = 0; b < 2; b++) exp_q.push_back(mk(32'h200 + 2*p + b, 4'hF, b == 1));
        end
        run_until_empty(100, n);
        n_cmp++;
        if (n != 24 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rr_cycles: got %0d cycles left=%0d, required 24/0", n, exp_q.size());
        end
        n_cmp++;
        if (pkt_count !== {16'd4, 16'd4}) begin
            n_err++;
            $display("FAIL rr_count: got %h, required 00040004", pkt_count);
        end
    endtask

    task automatic test_stall();
        logic [7:0] rdy, hld;
        int n;
        rdy = 8'b1111_1001;  // bit c-1 for cycle c
        hld = 8'b0011_0000;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src1.push_back(mk(32'hB0 + i, 4'hF, i == 3));
            exp_q.push_back(mk(32'hB0 + i, 4'hF, i == 3));
        end
        for (int i = 0; i < 2; i++) exp_q.push_back(mk(32'hC0 + i, 4'hF, i == 1));
        tick();
        for (int i = 0; i < 2; i++) src0.push_back(mk(32'hC0 + i, 4'hF, i == 1));
        for (int c = 1; c <= 8; c++) begin
            out_TREADY = rdy[c-1];
            hold[1]    = hld[c-1];
            tick();
            n_cmp++;
            if ({s_grant, s_tready[0]} !== 3'b100) begin
                n_err++;
                $display("FAIL stall_c%0d: got grant=%b tready0=%b, required 10/0", c, s_grant, s_tready[0]);
            end
        end
        out_TREADY = 1'b1; hold = '0;
        run_until_empty(20, n);
        tick(); tick();
        n_cmp++;
        if (exp_q.size() != 0 || pkt_count !== {16'd1, 16'd1}) begin
            n_err++;
            $display("FAIL stall_end: got left=%0d cnt=%h, required 0/00010001", exp_q.size(), pkt_count);
        end
    endtask

    task automatic test_arb_enable();
        int n, bc;
        do_reset();
        arb_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            src0.push_back(mk(32'hD0 + i, 4'hF, i == 2));
            exp_q.push_back(mk(32'hD0 + i, 4'hF, i == 2));
        end
        bc = 0;
        repeat (10) begin tick(); if (s_busy) bc++; end
        n_cmp++;
        if (bc != 0 || exp_q.size() != 3) begin
            n_err++;
            $display("FAIL en_hold: got busy_cycles=%0d left=%0d, required 0/3", bc, exp_q.size());
        end
        arb_enable = 1'b1;
        tick(); tick();
        arb_enable = 1'b0;
        run_until_empty(10, n);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL en_midpkt: got left=%0d, required 0", exp_q.size());
        end
        src0.push_back(mk(32'hE0, 4'h1, 1'b1));
        exp_q.push_back(mk(32'hE0, 4'h1, 1'b1));
        bc = 0;
        repeat (6) begin tick(); if (s_busy) bc++; end
        n_cmp++;
        if (bc != 0 || exp_q.size() != 1) begin
            n_err++;
            $display("FAIL en_after: got busy_cycles=%0d left=%0d, required 0/1", bc, exp_q.size());
        end
        arb_enable = 1'b1;
        run_until_empty(10, n);
        n_cmp++;
        if (exp_q.size() != 0 || pkt_count[15:0] !== 16'd2) begin
            n_err++;
            $display("FAIL en_resume: got left=%0d cnt0=%0d, required 0/2", exp_q.size(), pkt_count[15:0]);
        end
    endtask

    task automatic test_oversize();
        int n;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            src0.push_back(mk(32'hF0 + i, 4'hF, i == 5));
            exp_q.push_back(mk(32'hF0 + i, 4'hF, i == 5));
        end
        repeat (4) tick();
        n_cmp++;
        if (oversize_err !== 1'b0) begin
            n_err++;
            $display("FAIL ovs_early: got %b, required 0", oversize_err);
        end
        tick();
        n_cmp++;
        if (oversize_err !== 1'b1) begin
            n_err++;
            $display("FAIL ovs_set: got %b, required 1", oversize_err);
        end
        run_until_empty(20, n);
        src0.push_back(mk(32'hF8, 4'hF, 1'b1));
        exp_q.push_back(mk(32'hF8, 4'hF, 1'b1));
        run_until_empty(20, n);
        tick();
        n_cmp++;
        if (exp_q.size() != 0 || oversize_err !== 1'b1 || pkt_count[15:0] !== 16'd2) begin
            n_err++;
            $display("FAIL ovs_sticky: got left=%0d err=%b cnt0=%0d, required 0/1/2",
                     exp_q.size(), oversize_err, pkt_count[15:0]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 5; i++) begin
            src0.push_back(mk(32'h50 + i, 4'hF, i == 4));
            exp_q.push_back(mk(32'h50 + i, 4'hF, i == 4));
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src0.delete(); exp_q.delete();
        tick();
        n_cmp++;
        if ({s_valid, s_grant} !== 3'b000 || pkt_count !== 32'd0 || oversize_err !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_state: got valid=%b grant=%b cnt=%h err=%b, required 0/00/0/0",
                     s_valid, s_grant, pkt_count, oversize_err);
        end
        src1.push_back(mk(32'h61, 4'hF, 1'b1));
        src0.push_back(mk(32'h60, 4'hF, 1'b1));
        exp_q.push_back(mk(32'h60, 4'hF, 1'b1));
        exp_q.push_back(mk(32'h61, 4'hF, 1'b1));
        run_until_empty(20, n);
        n_cmp++;
        if (exp_q.size() != 0 || pkt_count !== {16'd1, 16'd1}) begin
            n_err++;
            $display("FAIL rstmid_fresh: got left=%0d cnt=%h, required 0/00010001", exp_q.size(), pkt_count);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; arb_enable = 1'b1; out_TREADY = 1'b1; hold = '0;
        req_TVALID = '0; req_TDATA = '0; req_TKEEP = '0; req_TLAST = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_arb_enable();
        test_oversize();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
